mem_access_unit: RTL
====================

# mem_access_unit

Data-memory access stage directly downstream of the ALU. It takes the ALU result as the effective address and the second register read value as store data. It runs one load or store per request over a req/ack data-memory bus with variable wait states, and stalls the pipeline until the access completes. Load data is lane-aligned and sign- or zero-extended before it is handed to write-back.

## Interface
- TIMEOUT, 255: max BUSY cycles without mem_ack before abort (only with MEM_TIMEOUT_EN); range 1..65535
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ALUResult  in  32  effective byte address
- Read_data2  in  32  store data (low bits used for byte/half)
- MemRead  in  1  load request
- MemWrite  in  1  store request; wins if MemRead also high
- MemSize  in  2  00 byte, 01 half, 10/11 word
- MemSignExt  in  1  1 = sign-extend byte/half loads
- Stall  out  1  hold upstream stages and inputs
- Done  out  1  one-cycle completion pulse
- MemData  out  32  formatted load result
- Misaligned  out  1  one-cycle alignment-error pulse
- BusError  out  1  one-cycle timeout pulse
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {ALUResult[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  bus completion; sampled only while mem_req=1
- mem_rdata  in  32  read word, valid with mem_ack

## Operation
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE:
  - Stall = MemRead|MemWrite (combinational).
  - If the request is aligned: latch address, lane, size, sign, write flag and formatted wdata/be, then go to BUSY.
  - If misaligned (half with addr[0]=1, word with addr[1:0]≠0): go to ERR; no bus cycle.
- BUSY:
  - mem_req=1 and Stall=1; mem_we/mem_addr/mem_wdata/mem_be stable.
  - On mem_ack: a load registers MemData, then go to DONE.
- DONE: Done=1, Stall=0. Always go to IDLE; the still-present request is ignored this cycle (no replay).
- ERR: Misaligned=1 (or BusError=1 on timeout), Stall=0, then go to IDLE.
- Byte enables by lane L=addr[1:0]:
  - byte: 0001<<L, wdata = {4{Read_data2[7:0]}}
  - half: 0011<<L, wdata = {2{Read_data2[15:0]}}
  - word: 1111, wdata = Read_data2
- Load formatting: shift mem_rdata right by 8*L, keep 8/16/32 bits, extend per MemSignExt; word ignores MemSignExt.
- MemData holds its value until the next load completes. Stores, errors and timeouts leave it unchanged.

## Timing
- Reset: state IDLE. Stall, Done, Misaligned, BusError, mem_req and mem_we are 0; MemData, mem_addr, mem_wdata and mem_be are 0.
- Asserting rst_n low mid-BUSY drops mem_req immediately. A late mem_ack is ignored.
- Minimum aligned access, ack in the first BUSY cycle:
  - cycle 0 IDLE, Stall=1
  - cycle 1 BUSY, mem_req=1, ack
  - cycle 2 DONE, Done=1, Stall=0
  - Total 2 stall cycles; each wait state adds one.
- Misaligned: cycle 0 IDLE with Stall=1, cycle 1 ERR with Misaligned=1.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE/ERR.
- mem_ack is ignored outside BUSY.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A BUSY-cycle counter, reset on entry to BUSY, aborts when it reaches TIMEOUT without ack.
  - On abort: mem_req drops, go to ERR with BusError=1; MemData is unchanged.
- MEM_TIMEOUT_EN undefined: BUSY waits indefinitely; BusError is tied 0 and there is no counter.

## Test plan
- Word load: addr 0x0000_0104, ack after 3 wait cycles, rdata 0xDEAD_BEEF -> mem_addr 0x104, be 1111, Stall high 5 cycles, Done pulse, MemData 0xDEAD_BEEF.
- Signed byte load: addr 0x0000_0203, rdata 0x80FF_1234, MemSignExt=1 -> MemData 0xFFFF_FF80; with MemSignExt=0 -> 0x0000_0080.
- Half store: addr 0x0000_0012, Read_data2 0x1234_ABCD -> mem_we=1, be 1100, wdata 0xABCD_ABCD, MemData unchanged.
- Misaligned word load: addr 0x0000_0006 -> no mem_req, Misaligned pulse in cycle 1, Stall low in cycle 1.
- Request held through DONE -> exactly one bus transaction. Reset asserted mid-BUSY -> mem_req falls without waiting for a clock edge, all outputs return to 0.
- With MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> mem_req for 4 cycles, then BusError pulse and Stall low.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access stage: one load/store per request over a req/ack bus, with lane formatting.
// Optional MEM_TIMEOUT_EN adds a BUSY watchdog that aborts to ERR with a BusError pulse.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALUResult,
  input  logic [31:0] Read_data2,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSignExt,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] MemData,
  output logic        Misaligned,
  output logic        BusError,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t      state, state_next;
  logic        req_any, misalign, timeout_hit, err_pulse;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt, shifted, load_fmt;
  logic [1:0]  lane_q, size_q;
  logic        sign_q, we_q, bus_err_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  assign req_any = MemRead | MemWrite;

  always_comb begin
    misalign  = 1'b0;
    be_fmt    = '0;
    wdata_fmt = '0;
    case (MemSize)
      2'b00: begin
        be_fmt    = 4'b0001 << ALUResult[1:0];
        wdata_fmt = {4{Read_data2[7:0]}};
      end
      2'b01: begin
        misalign  = ALUResult[0];
        be_fmt    = 4'b0011 << ALUResult[1:0];
        wdata_fmt = {2{Read_data2[15:0]}};
      end
      default: begin
        misalign  = |ALUResult[1:0];
        be_fmt    = '1;
        wdata_fmt = Read_data2;
      end
    endcase
  end

  always_comb begin
    shifted  = mem_rdata >> {lane_q, 3'b000};
    load_fmt = shifted;
    case (size_q)
      2'b00:   load_fmt = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_fmt = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [15:0] busy_cnt;

  // Counter is held at zero outside BUSY, so every BUSY entry starts from zero.
  assign timeout_hit = (state == BUSY) && !mem_ack && (busy_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              busy_cnt <= '0;
    else if (state != BUSY)  busy_cnt <= '0;
    else                     busy_cnt <= busy_cnt + 16'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_any) state_next = misalign ? ERR : BUSY;
      BUSY: begin
        if (mem_ack)          state_next = DONE;
        else if (timeout_hit) state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      sign_q    <= 1'b0;
      we_q      <= 1'b0;
      bus_err_q <= 1'b0;
      MemData   <= '0;
    end else begin
      if (state == IDLE && req_any && !misalign) begin
        addr_q  <= {ALUResult[31:2], 2'b00};
        wdata_q <= wdata_fmt;
        be_q    <= be_fmt;
        lane_q  <= ALUResult[1:0];
        size_q  <= MemSize;
        sign_q  <= MemSignExt;
        we_q    <= MemWrite;
      end
      if (state_next == ERR) bus_err_q <= (state == BUSY);
      if (state == BUSY && mem_ack && !we_q) MemData <= load_fmt;
    end
  end

  always_comb begin
    Stall     = 1'b0;
    Done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    err_pulse = 1'b0;
    case (state)
      IDLE: Stall = req_any;
      BUSY: begin
        Stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = we_q;
      end
      DONE:    Done = 1'b1;
      ERR:     err_pulse = 1'b1;
      default: ;
    endcase
  end

  assign Misaligned = err_pulse & ~bus_err_q;
`ifdef MEM_TIMEOUT_EN
  assign BusError   = err_pulse & bus_err_q;
`else
  assign BusError   = 1'b0;
`endif

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

endmodule
